// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Round-robin arbiter for the single register-file write port. Channel A
// carries ALU results and channel B carries load results. One transfer is
// accepted per cycle through valid/ready. The winning destination and data
// are registered onto the write port one cycle later. Writes to register 0
// are accepted and counted, but wr_en stays low for them.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_valid/a_addr/a_data    channel A (ALU) request; a_ready accepts it
//   b_valid/b_addr/b_data    channel B (load) request; b_ready accepts it
//   stall                    write port busy, no grant while high
//   clr_cnt                  synchronous clear of both transfer counters
//   sel                      registered write-back MUX select (0 = A, 1 = B)
//   wr_en/wr_addr/wr_data    registered register-file write port
//   cnt_a/cnt_b              saturating per-channel transfer counters
module wb_port_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             stall,
  input  logic             clr_cnt,
  output logic             sel,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e             pri_q, pri_d;
  logic             sel_q, sel_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [15:0]      cnt_a_q, cnt_a_d;
  logic [15:0]      cnt_b_q, cnt_b_d;

  logic grant_a, grant_b;
  logic xfer_a, xfer_b;

  // Grants depend only on valids and priority, never on the readys.
  assign grant_a = a_valid & (~b_valid | (pri_q == PRI_A));
  assign grant_b = b_valid & (~a_valid | (pri_q == PRI_B));

  // rst_n gates the readys so nothing is accepted while reset is held.
  assign a_ready = grant_a & ~stall & rst_n;
  assign b_ready = grant_b & ~stall & rst_n;

  assign xfer_a = a_valid & a_ready;
  assign xfer_b = b_valid & b_ready;

  always_comb begin
    pri_d     = pri_q;
    sel_d     = sel_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;

    // Data of the losing or idle channel is never selected, so X on a
    // non-valid channel cannot reach the port.
    if (xfer_a) begin
      pri_d     = PRI_B;
      sel_d     = 1'b0;
      wr_addr_d = a_addr;
      wr_data_d = a_data;
      wr_en_d   = (a_addr != '0);
    end else if (xfer_b) begin
      pri_d     = PRI_A;
      sel_d     = 1'b1;
      wr_addr_d = b_addr;
      wr_data_d = b_data;
      wr_en_d   = (b_addr != '0);
    end

    if (clr_cnt) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (xfer_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 16'd1;
      if (xfer_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q     <= PRI_A;
      sel_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      pri_q     <= pri_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign sel     = sel_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Self-checking bench for wb_port_arbiter. A behavioural model tracks who
// wins the next tie, the last write presented and the transfer counts; each
// cycle the readys and the registered port are compared against it.
module tb_wb_port_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, b_valid, stall, clr_cnt;
  logic [AW-1:0]    a_addr, b_addr;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, sel, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [15:0]      cnt_a, cnt_b;

  always #5 clk = ~clk;

  wb_port_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .clr_cnt(clr_cnt),
    .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_a_wins_tie;
  bit          m_sel, m_en;
  int unsigned m_addr;
  logic [31:0] m_data;
  int unsigned m_ca, m_cb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a_wins_tie = 1'b1;
    m_sel = 1'b0; m_en = 1'b0; m_addr = 0; m_data = '0;
    m_ca = 0; m_cb = 0;
  endtask

  task automatic drive(input bit av, input int unsigned aa, input logic [31:0] ad,
                       input bit bv, input int unsigned ba, input logic [31:0] bd,
                       input bit st, input bit clr);
    a_valid = av; a_addr = aa[AW-1:0]; a_data = ad;
    b_valid = bv; b_addr = ba[AW-1:0]; b_data = bd;
    stall = st; clr_cnt = clr;
  endtask

  task automatic check_port();
    check("wr_en",   wr_en,   m_en);
    check("sel",     sel,     m_sel);
    check("wr_addr", wr_addr, m_addr);
    check("wr_data", wr_data, m_data);
    check("cnt_a",   cnt_a,   m_ca);
    check("cnt_b",   cnt_b,   m_cb);
  endtask

  // Called in the low phase with inputs already driven; returns in the next
  // low phase after checking both the readys and the registered port.
  task automatic cycle();
    bit ea, eb;
    #1;
    ea = a_valid && !stall && (!b_valid || m_a_wins_tie);
    eb = b_valid && !stall && (!a_valid || !m_a_wins_tie);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    @(posedge clk);
    m_en = 1'b0;
    if (ea) begin
      m_sel = 1'b0; m_addr = a_addr; m_data = a_data; m_en = (a_addr != 0);
      m_a_wins_tie = 1'b0;
    end else if (eb) begin
      m_sel = 1'b1; m_addr = b_addr; m_data = b_data; m_en = (b_addr != 0);
      m_a_wins_tie = 1'b1;
    end
    if (clr_cnt) begin
      m_ca = 0; m_cb = 0;
    end else begin
      if (ea && m_ca < 65535) m_ca++;
      if (eb && m_cb < 65535) m_cb++;
    end
    #1;
    check_port();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_port", {wr_en, sel, wr_addr, wr_data}, '0);
    check_port();
    rst_n = 1'b1;

    // Alternation with both channels continuously valid
    drive(1, 3, 32'hAAAAAAAA, 1, 4, 32'h55555555, 0, 0);
    repeat (4) cycle();
    check("alt_cnt_a", cnt_a, 16'd2);
    check("alt_cnt_b", cnt_b, 16'd2);

    // Single requester B
    drive(0, 0, '0, 1, 7, 32'hFFFFFFFF, 0, 0);
    repeat (3) cycle();
    check("single_cnt_b", cnt_b, 16'd5);

    // Zero-register write from A
    drive(1, 0, 32'hA5A5A5A5, 0, 0, '0, 0, 0);
    cycle();
    check("zero_wr_en", wr_en, 1'b0);
    check("zero_wr_data", wr_data, 32'hA5A5A5A5);

    // Stall with both valid; B holds priority after A's zero write
    drive(1, 9, 32'h11111111, 1, 10, 32'h22222222, 1, 0);
    repeat (2) cycle();
    stall = 1'b0;
    cycle();
    check("post_stall_sel", sel, 1'b1);

    // Reset mid-stream with both valid
    drive(1, 12, 32'hCAFEF00D, 1, 13, 32'hDEADBEEF, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check_port();
    @(posedge clk); #1;
    check_port();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_rst_sel", sel, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), $urandom,
            $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      cycle();
    end

    // Counter saturation on A, then clear during a transfer
    drive(0, 0, '0, 0, 0, '0, 0, 1);
    cycle();
    clr_cnt = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      drive(1, (i % 31) + 1, i, 0, 0, '0, 0, 0);
      cycle();
    end
    check("sat_cnt_a", cnt_a, 16'hFFFF);
    cycle();
    check("sat_hold_cnt_a", cnt_a, 16'hFFFF);
    clr_cnt = 1'b1;
    cycle();
    check("clr_cnt_a", cnt_a, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port between two result producers: channel A is the ALU result and channel B is the memory load result. It accepts one transfer per cycle through a valid/ready handshake. It drives the select line of the 32-bit 2-to-1 write-back MUX and registers the winning destination and data onto the write port. Writes to register 0 are accepted but never asserted on the port, because $zero is hard-wired.

## Interface
Parameters:
- WIDTH, 32, data width of each channel and of the write port
- AW, 5, register address width

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  channel A (ALU) has a result
- a_addr  in  AW  channel A destination register
- a_data  in  WIDTH  channel A result
- a_ready  out  1  channel A transfer accepted this cycle (combinational)
- b_valid  in  1  channel B (load) has a result
- b_addr  in  AW  channel B destination register
- b_data  in  WIDTH  channel B result
- b_ready  out  1  channel B transfer accepted this cycle (combinational)
- stall  in  1  write port unavailable; no grant issued while high
- clr_cnt  in  1  synchronous clear of grant counters
- sel  out  1  registered MUX select: 0 = A, 1 = B
- wr_en  out  1  registered write enable to register file
- wr_addr  out  AW  registered write address
- wr_data  out  WIDTH  registered write data
- cnt_a  out  16  saturating count of A transfers
- cnt_b  out  16  saturating count of B transfers

## Operation
- Priority FSM has two states. In PRI_A, A wins a tie; in PRI_B, B wins a tie. Reset state is PRI_A.
- Grant, when stall = 0:
  - Only one valid: that channel is granted.
  - Both valid: the priority holder is granted.
  - Neither valid: no grant.
- Readiness: a_ready = grant_a & ~stall and b_ready = grant_b & ~stall. At most one ready is high in any cycle. The ready signals never depend on the ready outputs themselves.
- Transfer on a channel means valid & ready on that channel.
- FSM transitions:
  - Transfer on A moves the FSM to PRI_B.
  - Transfer on B moves the FSM to PRI_A.
  - No transfer: the state holds.
- On a transfer, the following register updates occur on the next edge:
  - sel takes the granted channel.
  - wr_addr and wr_data take the granted channel's addr and data.
  - wr_en is set to (addr != 0).
- With no transfer, wr_en = 0 on the next edge, and sel, wr_addr and wr_data hold their last values.
- Counters: cnt_a and cnt_b each increment by 1 on a transfer of their own channel, including transfers with addr = 0. Each saturates at 16'hFFFF and does not wrap.
- clr_cnt = 1 zeroes both counters on the next edge. It takes precedence over a same-cycle increment.
- Reset (rst_n low, any time, asynchronous) immediately forces:
  - sel = 0, wr_en = 0, wr_addr = 0, wr_data = 0
  - cnt_a = 0, cnt_b = 0
  - FSM = PRI_A
  - a_ready = b_ready = 0 while rst_n is low
- A transfer in flight during reset is dropped. No write is issued after release unless it is re-presented.
- Inputs are sampled only when valid is high. X on addr or data of a non-valid channel must not propagate to the outputs.

## Timing
- Latency is one cycle from a transfer edge to wr_en, wr_addr, wr_data and sel valid at the port.
- Throughput is one write per cycle. With both channels continuously valid and stall = 0, the grants alternate A, B, A, B…
- stall high blocks both readys in the same cycle. The FSM holds, and wr_en is 0 on the following cycle.
- Channels hold valid, addr and data stable until their ready is seen high. The arbiter does not buffer refused requests.
- First cycle after reset release:
  - If both channels are valid, A is granted.
  - If only B is valid, B is granted and the FSM moves to PRI_A.

## Test plan
- Reset: assert rst_n = 0 mid-stream with both channels valid → all outputs are 0 immediately and both readys are 0. After release with both valid, A is granted first.
- Alternation: hold a_valid = b_valid = 1 with a_addr = 3, a_data = 32'hAAAAAAAA, b_addr = 4, b_data = 32'h55555555 for 4 cycles → the write port shows (3, AAAAAAAA, sel 0), (4, 55555555, sel 1), then repeats. cnt_a = cnt_b = 2.
- Single requester: only B valid for 3 cycles with b_data = 32'hFFFFFFFF → b_ready is high every cycle, wr_en is high 3 cycles with sel = 1, and cnt_b = 3.
- Zero register: A transfers with a_addr = 0, a_data = 32'hA5A5A5A5 → wr_en = 0 on the next cycle, wr_data = A5A5A5A5, cnt_a increments, FSM moves to PRI_B.
- Stall: both valid, stall = 1 for 2 cycles → both readys are 0, wr_en = 0, outputs hold, FSM holds. After stall drops, the previous priority holder is granted.
- Counters: preload by running A for 65 537 transfers → cnt_a = 16'hFFFF and stays there. clr_cnt asserted during an A transfer → cnt_a = 0 on the next edge.
